// File: rtl/v_defines.sv
// Shared definitions for the vector memory-access stage.
// Holds the datapath widths, the in_op encoding, the stage FSM state encoding
// and the beat-alignment helper used at op accept.
package v_defines;

  localparam int unsigned VREG_WIDTH = 256;  // vector register width (VLMAX*SEW)
  localparam int unsigned MEM_DW     = 64;   // memory data-port width
  localparam int unsigned ADDR_W     = 32;   // byte-address width
  localparam int unsigned VIDX_W     = 5;    // vector register index width

  localparam int unsigned NBEATS     = VREG_WIDTH / MEM_DW;
  localparam int unsigned BEAT_BYTES = MEM_DW / 8;
  localparam int unsigned CNT_W      = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [1:0] {
    VMEM_OP_NOP   = 2'd0,
    VMEM_OP_ALU   = 2'd1,
    VMEM_OP_LOAD  = 2'd2,
    VMEM_OP_STORE = 2'd3
  } vmem_op_e;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StPass = 3'd1,
    StReq  = 3'd2,
    StWait = 3'd3,
    StDone = 3'd4
  } vmem_state_e;

  // Clear the byte-offset bits so every beat is naturally aligned to MEM_DW.
  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(BEAT_BYTES - 1);
  endfunction

endpackage

// File: rtl/v_mem_stage_if.sv
// Bus bundle of the vector memory-access stage.
//   in_*  : upstream op handshake (valid/ready, op, vd, base address, data)
//   mem_* : single-outstanding memory port (req/gnt, we, addr, wdata, rvalid/rdata)
//   wb_*  : one-cycle write-back strobe with register index and data
// slave  : the stage itself; master : the environment around it.
interface v_mem_stage_if;
  import v_defines::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_op;
  logic [VIDX_W-1:0]     in_vd;
  logic [ADDR_W-1:0]     in_addr;
  logic [VREG_WIDTH-1:0] in_data;

  logic                  mem_req;
  logic                  mem_gnt;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [MEM_DW-1:0]     mem_wdata;
  logic                  mem_rvalid;
  logic [MEM_DW-1:0]     mem_rdata;

  logic                  wb_valid;
  logic [VIDX_W-1:0]     wb_vd;
  logic [VREG_WIDTH-1:0] wb_data;

  modport slave (
    input  in_valid, in_op, in_vd, in_addr, in_data,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output in_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output wb_valid, wb_vd, wb_data
  );

  modport master (
    output in_valid, in_op, in_vd, in_addr, in_data,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  in_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  wb_valid, wb_vd, wb_data
  );

endinterface

// File: rtl/v_mem_beat_sel.sv
// Combinational beat helper for the vector memory-access stage.
//   vec_i  : full vector register       idx_i  : beat index k
//   beat_i : beat to insert at k        base_i : aligned base byte address
//   beat_o : vec_i[k*MEM_DW +: MEM_DW]  vec_o  : vec_i with beat k replaced by beat_i
//   addr_o : base_i + k*BEAT_BYTES, wrapping modulo 2^ADDR_W
module v_mem_beat_sel
  import v_defines::*;
(
  input  logic [VREG_WIDTH-1:0] vec_i,
  input  logic [CNT_W-1:0]      idx_i,
  input  logic [MEM_DW-1:0]     beat_i,
  input  logic [ADDR_W-1:0]     base_i,
  output logic [MEM_DW-1:0]     beat_o,
  output logic [VREG_WIDTH-1:0] vec_o,
  output logic [ADDR_W-1:0]     addr_o
);

  // Constant-slice mux keeps every select statically bounded.
  always_comb begin
    beat_o = '0;
    vec_o  = vec_i;
    for (int unsigned b = 0; b < NBEATS; b++) begin
      if (idx_i == CNT_W'(b)) begin
        beat_o                     = vec_i[b*MEM_DW +: MEM_DW];
        vec_o[b*MEM_DW +: MEM_DW]  = beat_i;
      end
    end
  end

  assign addr_o = base_i + (ADDR_W'(idx_i) * ADDR_W'(BEAT_BYTES));

endmodule

// File: rtl/v_mem_stage.sv
// Vector memory-access stage, downstream of vector execute.
// Accepts one op per handshake: NOP, ALU-result passthrough, unit-stride load or store.
// Loads/stores are split into NBEATS beats of MEM_DW bits on a single-outstanding
// memory port; ALU-pass and completed loads produce one write-back strobe.
//   clk : clock, rising edge      rst : asynchronous, active-low reset
//   bus : in_* op handshake, mem_* memory port, wb_* write-back strobe
module v_mem_stage
  import v_defines::*;
(
  input logic          clk,
  input logic          rst,
  v_mem_stage_if.slave bus
);

  vmem_state_e           state_q, state_d;
  vmem_op_e              op_q, op_d;
  logic [VIDX_W-1:0]     vd_q, vd_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [VREG_WIDTH-1:0] data_q, data_d;     // store data or load gather buffer
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [VIDX_W-1:0]     wb_vd_q, wb_vd_d;
  logic [VREG_WIDTH-1:0] wb_data_q, wb_data_d;

  logic [MEM_DW-1:0]     beat_cur;
  logic [VREG_WIDTH-1:0] data_ins;
  logic [ADDR_W-1:0]     beat_addr;
  logic                  last_beat;
  logic                  req;
  logic                  we;

  v_mem_beat_sel u_beat_sel (
    .vec_i  (data_q),
    .idx_i  (cnt_q),
    .beat_i (bus.mem_rdata),
    .base_i (addr_q),
    .beat_o (beat_cur),
    .vec_o  (data_ins),
    .addr_o (beat_addr)
  );

  assign last_beat = (cnt_q == CNT_W'(NBEATS - 1));

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    vd_d       = vd_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    wb_valid_d = 1'b0;
    wb_vd_d    = wb_vd_q;
    wb_data_d  = wb_data_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          op_d   = vmem_op_e'(bus.in_op);
          vd_d   = bus.in_vd;
          addr_d = align_addr(bus.in_addr);
          data_d = bus.in_data;
          cnt_d  = '0;
          unique case (vmem_op_e'(bus.in_op))
            VMEM_OP_NOP: state_d = StIdle;
            VMEM_OP_ALU: begin
              // Strobe is registered, so it appears the cycle after accept.
              state_d    = StPass;
              wb_valid_d = 1'b1;
              wb_vd_d    = bus.in_vd;
              wb_data_d  = bus.in_data;
            end
            default:     state_d = StReq;
          endcase
        end
      end

      StPass, StDone: state_d = StIdle;

      StReq: begin
        if (bus.mem_gnt) begin
          if (op_q == VMEM_OP_STORE) begin
            if (last_beat) state_d = StIdle;
            else           cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            state_d = StWait;
          end
        end
      end

      StWait: begin
        if (bus.mem_rvalid) begin
          data_d = data_ins;
          if (last_beat) begin
            state_d    = StDone;
            wb_valid_d = 1'b1;
            wb_vd_d    = vd_q;
            wb_data_d  = data_ins;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = StReq;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      op_q       <= VMEM_OP_NOP;
      vd_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_vd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      vd_q       <= vd_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_vd_q    <= wb_vd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // Memory outputs are gated to zero outside REQ; the beat helper holds them
  // stable while stalled because cnt/addr/data do not move until gnt.
  assign req           = (state_q == StReq);
  assign we            = req && (op_q == VMEM_OP_STORE);
  assign bus.in_ready  = (state_q == StIdle);
  assign bus.mem_req   = req;
  assign bus.mem_we    = we;
  assign bus.mem_addr  = req ? beat_addr : '0;
  assign bus.mem_wdata = we ? beat_cur : '0;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_vd     = wb_vd_q;
  assign bus.wb_data   = wb_data_q;

endmodule

// File: tb/tb_v_mem_stage.sv
// Bench for v_mem_stage: directed scenarios plus randomized ops checked against a
// byte-addressed memory model and a per-op expectation derived from the op rules.
module tb_v_mem_stage;
  import v_defines::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  v_mem_stage_if bus ();

  v_mem_stage u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [MEM_DW-1:0]     mem_model [bit [ADDR_W-1:0]];
  int                    stall_pat [NBEATS];
  bit                    use_pat   = 1'b0;
  int                    fixed_lat = 0;
  logic [VIDX_W-1:0]     last_vd   = '0;
  logic [VREG_WIDTH-1:0] last_data = '0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [MEM_DW-1:0] rd_mem(input logic [ADDR_W-1:0] a);
    if (!mem_model.exists(a)) mem_model[a] = {$urandom, $urandom};
    return mem_model[a];
  endfunction

  function automatic logic [VREG_WIDTH-1:0] rand_vec();
    logic [VREG_WIDTH-1:0] v;
    for (int i = 0; i < VREG_WIDTH / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.in_valid   = 1'b0;
    bus.in_op      = 2'd0;
    bus.in_vd      = '0;
    bus.in_addr    = '0;
    bus.in_data    = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"},   256'(bus.mem_req),   256'(0));
    check({tag, "_mem_we"},    256'(bus.mem_we),    256'(0));
    check({tag, "_mem_addr"},  256'(bus.mem_addr),  256'(0));
    check({tag, "_mem_wdata"}, 256'(bus.mem_wdata), 256'(0));
    check({tag, "_wb_valid"},  256'(bus.wb_valid),  256'(0));
    check({tag, "_wb_vd"},     256'(bus.wb_vd),     256'(0));
    check({tag, "_wb_data"},   256'(bus.wb_data),   256'(0));
  endtask

  // Drives one op from a negedge and follows it to completion, acting as the memory.
  // abort_beat >= 0 pulses reset while waiting for that load beat's data.
  task automatic run_op(input logic [1:0] op, input logic [VIDX_W-1:0] vd,
                        input logic [ADDR_W-1:0] addr, input logic [VREG_WIDTH-1:0] data,
                        input int abort_beat);
    logic [ADDR_W-1:0]     base;
    logic [ADDR_W-1:0]     a;
    logic [MEM_DW-1:0]     beat;
    logic [VREG_WIDTH-1:0] exp_vec;
    int                    stall;
    int                    lat;
    base    = addr - (addr % BEAT_BYTES);
    exp_vec = '0;
    check("in_ready_before", 256'(bus.in_ready), 256'(1));
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_vd    = vd;
    bus.in_addr  = addr;
    bus.in_data  = data;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = rand_vec();
    if (op == 2'd0) begin
      check("nop_wb_valid", 256'(bus.wb_valid), 256'(0));
      check("nop_mem_req",  256'(bus.mem_req),  256'(0));
      check("nop_in_ready", 256'(bus.in_ready), 256'(1));
      return;
    end
    if (op == 2'd1) begin
      check("alu_wb_valid", 256'(bus.wb_valid), 256'(1));
      check("alu_wb_vd",    256'(bus.wb_vd),    256'(vd));
      check("alu_wb_data",  bus.wb_data,        data);
      check("alu_mem_req",  256'(bus.mem_req),  256'(0));
      check("alu_busy",     256'(bus.in_ready), 256'(0));
      last_vd   = vd;
      last_data = data;
      @(negedge clk);
      check("alu_wb_drop",  256'(bus.wb_valid), 256'(0));
      check("alu_wb_hold",  bus.wb_data,        last_data);
      check("alu_in_ready", 256'(bus.in_ready), 256'(1));
      return;
    end
    for (int k = 0; k < NBEATS; k++) begin
      a     = base + ADDR_W'(k * BEAT_BYTES);
      stall = use_pat ? stall_pat[k] : int'($urandom_range(0, 2));
      for (int s = 0; s <= stall; s++) begin
        check("req",      256'(bus.mem_req),  256'(1));
        check("we",       256'(bus.mem_we),   256'(op == 2'd3));
        check("addr",     256'(bus.mem_addr), 256'(a));
        if (op == 2'd3) check("wdata", 256'(bus.mem_wdata), 256'(data[k*MEM_DW +: MEM_DW]));
        check("busy_req", 256'(bus.in_ready), 256'(0));
        if (s < stall) begin
          // Stalled: junk rvalid and an op offer must both be ignored.
          bus.mem_rvalid = 1'($urandom_range(0, 1));
          bus.mem_rdata  = {$urandom, $urandom};
          bus.in_valid   = 1'($urandom_range(0, 1));
          bus.in_op      = 2'($urandom_range(0, 3));
          @(posedge clk);
          @(negedge clk);
          bus.mem_rvalid = 1'b0;
          bus.in_valid   = 1'b0;
        end else begin
          bus.mem_gnt = 1'b1;
          @(posedge clk);
          @(negedge clk);
          bus.mem_gnt = 1'b0;
        end
      end
      if (op == 2'd3) begin
        mem_model[a] = data[k*MEM_DW +: MEM_DW];
        continue;
      end
      lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 3));
      for (int w = 1; w < lat; w++) begin
        check("wait_req",  256'(bus.mem_req),  256'(0));
        check("wait_busy", 256'(bus.in_ready), 256'(0));
        @(posedge clk);
        @(negedge clk);
      end
      if (k == abort_beat) begin
        rst = 1'b0;
        #1;
        check_all_zero("abort");
        last_vd   = '0;
        last_data = '0;
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      beat = rd_mem(a);
      exp_vec[k*MEM_DW +: MEM_DW] = beat;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = beat;
      @(posedge clk);
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = {$urandom, $urandom};
    end
    if (op == 2'd2) begin
      check("ld_wb_valid", 256'(bus.wb_valid), 256'(1));
      check("ld_wb_vd",    256'(bus.wb_vd),    256'(vd));
      check("ld_wb_data",  bus.wb_data,        exp_vec);
      last_vd   = vd;
      last_data = exp_vec;
      @(negedge clk);
      check("ld_wb_drop",  256'(bus.wb_valid), 256'(0));
    end else begin
      check("st_no_wb",    256'(bus.wb_valid), 256'(0));
      check("st_mem_req",  256'(bus.mem_req),  256'(0));
    end
    check("done_wb_hold",  bus.wb_data,        last_data);
    check("done_in_ready", 256'(bus.in_ready), 256'(1));
  endtask

  initial begin
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    idle_inputs();
    rst = 1'b0;
    #1;
    check("rst_in_ready", 256'(bus.in_ready), 256'(1));
    check_all_zero("rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_op(2'd1, 5'd3, 32'h0, 256'h0807060504030201, -1);

    use_pat   = 1'b1;
    stall_pat = '{0, 2, 0, 1};
    run_op(2'd3, 5'd0, 32'h1000,
           {64'hB3B3_B3B3_B3B3_B3B3, 64'hB2B2_B2B2_B2B2_B2B2,
            64'hB1B1_B1B1_B1B1_B1B1, 64'hB0B0_B0B0_B0B0_B0B0}, -1);
    use_pat = 1'b0;

    mem_model[32'h2000] = 64'h1111_1111_1111_1111;
    mem_model[32'h2008] = 64'h2222_2222_2222_2222;
    mem_model[32'h2010] = 64'h3333_3333_3333_3333;
    mem_model[32'h2018] = 64'h4444_4444_4444_4444;
    fixed_lat = 3;
    run_op(2'd2, 5'd7, 32'h2004, '0, -1);
    fixed_lat = 0;
    check("ld_literal", last_data,
          {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

    run_op(2'd2, 5'd9, 32'hFFFF_FFF0, '0, -1);

    // Stray read data while idle must not disturb anything.
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = {$urandom, $urandom};
    @(posedge clk);
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    check("idle_rv_wb",    256'(bus.wb_valid), 256'(0));
    check("idle_rv_hold",  bus.wb_data,        last_data);
    check("idle_rv_ready", 256'(bus.in_ready), 256'(1));

    run_op(2'd2, 5'd12, 32'h3000, '0, 2);
    check("post_abort_wb", 256'(bus.wb_valid), 256'(0));
    run_op(2'd2, 5'd13, 32'h3000, '0, -1);
    run_op(2'd0, 5'd1, 32'h0, rand_vec(), -1);
    run_op(2'd1, 5'd4, 32'h0, rand_vec(), -1);
    run_op(2'd1, 5'd5, 32'h0, rand_vec(), -1);

    for (int i = 0; i < 40; i++) begin
      op   = 2'($urandom_range(0, 3));
      addr = ($urandom_range(0, 3) != 0) ? 32'h4000 + 32'($urandom_range(0, 63)) : $urandom;
      run_op(op, 5'($urandom_range(0, 31)), addr, rand_vec(), -1);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        check("gap_wb", 256'(bus.wb_valid), 256'(0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/v_mem_stage.md
Name: v_mem_stage

Overview:
- Vector memory-access stage directly downstream of the vector execute stage. Accepts one vector op per handshake: ALU result passthrough, vector unit-stride load, or vector unit-stride store.
- Splits a full vector register into MEM_DW-wide beats on a single-outstanding memory port.
- Presents one write-back beat per completed op to the vector writeback stage.

Parameters:
- VREG_WIDTH, 256, vector register width in bits (VLMAX*SEW).
- MEM_DW, 64, memory data-port width in bits; VREG_WIDTH must be a multiple of it.
- ADDR_W, 32, byte-address width.
- VIDX_W, 5, vector register index width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream op valid
- in_ready  out  1  stage can accept an op
- in_op  in  2  0=NOP-pass, 1=ALU-pass, 2=LOAD, 3=STORE
- in_vd  in  VIDX_W  destination register index (LOAD/ALU-pass)
- in_addr  in  ADDR_W  base byte address (LOAD/STORE)
- in_data  in  VREG_WIDTH  ALU result (ALU-pass) or store data (STORE)
- mem_req  out  1  memory request valid
- mem_gnt  in  1  request accepted this cycle
- mem_we  out  1  1=write beat
- mem_addr  out  ADDR_W  beat byte address
- mem_wdata  out  MEM_DW  write beat data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  MEM_DW  read beat data
- wb_valid  out  1  one-cycle write-back strobe
- wb_vd  out  VIDX_W  write-back register index
- wb_data  out  VREG_WIDTH  write-back data

Behaviour:
- Reset (rst=0, async): state IDLE, beat counter 0, data buffer 0. Outputs: in_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, wb_valid=0, wb_vd=0, wb_data=0.
- NBEATS = VREG_WIDTH/MEM_DW. Beat k covers data[k*MEM_DW +: MEM_DW] at address base + k*(MEM_DW/8).
- Base address low log2(MEM_DW/8) bits forced to 0. Address arithmetic wraps modulo 2^ADDR_W.
- in_ready = (state==IDLE). Accept on in_valid & in_ready. Op, vd, aligned address and data are latched at accept.
- FSM states: IDLE, PASS, REQ, WAIT, DONE.
  - IDLE: on accept, NOP goes to IDLE with no output, ALU goes to PASS, LOAD/STORE go to REQ with counter = 0.
  - PASS: next cycle wb_valid=1, wb_vd=latched vd, wb_data=latched data, then IDLE. Latency accept→wb_valid = 1 cycle.
  - REQ: mem_req=1. mem_addr, mem_we and mem_wdata (store beat k) are held stable until mem_gnt.
    - On gnt for STORE: if k==NBEATS-1, go IDLE with no wb strobe; else k+1 and stay in REQ.
    - On gnt for LOAD: go WAIT.
  - WAIT: mem_req=0. On mem_rvalid, write beat k of the buffer. If last beat go DONE, else k+1 and go REQ. mem_rvalid is ignored in every state except WAIT.
  - DONE: wb_valid=1 with buffer and vd for exactly one cycle, then IDLE.
- Only one memory request is outstanding. mem_rvalid arriving in the same cycle as gnt is not legal; the earliest return is the cycle after gnt.
- wb outputs hold their last values when wb_valid=0. Downstream has no backpressure.
- Back-to-back ops: at best one new op accepted every 2 cycles for ALU-pass.
- Reset asserted mid-op aborts the op: partial store beats stay committed, the load buffer is discarded, and no wb strobe is issued.

Decomposition:
- Shared package v_defines holds VREG_WIDTH, MEM_DW, ADDR_W, VIDX_W, the in_op encodings (VMEM_OP_NOP/ALU/LOAD/STORE) and the FSM state encoding.
- One natural sub-module, v_mem_beat_sel: combinational beat-k slice/insert of a VREG_WIDTH vector plus beat address generation.

Test Plan:
- ALU-pass: in_op=1, vd=3, data=0x…0807060504030201 → wb_valid one cycle after accept, wb_vd=3, wb_data equal to the input data, mem_req never asserted.
- STORE: addr=0x1000, data beats B0..B3, gnt after 0/2/0/1 stall cycles → 4 writes to 0x1000/08/10/18 carrying B0..B3 in order, mem_addr/mem_wdata stable during stalls, no wb strobe, in_ready back high after the last gnt.
- LOAD: addr=0x2004 (misaligned), vd=7, rvalid latency 3, rdata=0x11..,0x22..,0x33..,0x44.. → addresses 0x2000..0x2018, wb_data={0x44..,0x33..,0x22..,0x11..}, wb_vd=7, wb_valid for exactly 1 cycle.
- Wrap: LOAD addr=0xFFFF_FFF0 → beat addresses 0xFFFF_FFF0, 0xFFFF_FFF8, 0x0, 0x8.
- Spurious rvalid during REQ/IDLE, plus in_valid while busy → buffer unchanged, in_ready=0, op not accepted.
- rst low during load beat 2 → all outputs zero at once, next LOAD completes with correct data and no stale wb.
